// File: rtl/gray_pkg.sv
// gray_pkg
// Shared definitions for Gray-code bus consumers.
//   gd_state_e : gray_decoder tracking-FSM encoding (GD_EMPTY/GD_TRACK/GD_FAULT)
//   GRAY_W     : default Gray bus width, matching the team's 3-bit counter
package gray_pkg;

  localparam int GRAY_W = 3;

  typedef enum logic [1:0] {
    GD_EMPTY = 2'd0,
    GD_TRACK = 2'd1,
    GD_FAULT = 2'd2
  } gd_state_e;

endpackage

// File: rtl/gray2bin.sv
// gray2bin
// Combinational Gray-to-binary decoder, reusable by any Gray bus consumer.
// Ports:
//   gray_i [WIDTH-1:0] : Gray-coded input
//   bin_o  [WIDTH-1:0] : binary value
module gray2bin #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  // Binary bit i is the XOR of all Gray bits from the MSB down to i.
  // Written as a reduction over a shifted copy so no bit of bin_o
  // depends on another bit of bin_o (no combinational self-loop).
  always_comb begin
    bin_o = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      bin_o[i] = ^(gray_i >> i);
    end
  end

endmodule

// File: rtl/gray_decoder.sv
// gray_decoder
// Samples a Gray-coded count bus on En, decodes it to binary, registers it
// and checks that each sample is a hold or a +1 (mod 2^WIDTH) step from the
// previous one.
// Ports:
//   Clk      : clock, rising edge
//   Reset    : synchronous active-high reset
//   En       : sample strobe
//   GrayIn   : Gray-coded count [WIDTH-1:0]
//   Binary   : decoded value of last accepted sample (registered)
//   Valid    : one-cycle pulse after each accepted sample (registered)
//   Overflow : sticky, forward wrap all-ones -> zero seen (registered)
//   Error    : sticky, illegal transition seen (registered)
// Configuration macro: GRAY_DECODER_SEQ_CHECK_EN
//   defined   : transition checking with EMPTY/TRACK/FAULT FSM
//   undefined : no checking, no FAULT state, Error tied low
module gray_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic [WIDTH-1:0] GrayIn,
  output logic [WIDTH-1:0] Binary,
  output logic             Valid,
  output logic             Overflow,
  output logic             Error
);

  gd_state_e        state_q, state_d;
  logic [WIDTH-1:0] binary_q, binary_d;
  logic             valid_q, valid_d;
  logic             overflow_q, overflow_d;
`ifdef GRAY_DECODER_SEQ_CHECK_EN
  logic             error_q, error_d;
`endif

  logic [WIDTH-1:0] dec_s;
  logic [WIDTH-1:0] succ_s;
  logic             prev_all_ones_s;

  gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
    .gray_i (GrayIn),
    .bin_o  (dec_s)
  );

  // The registered Binary is the reference; +1 wraps naturally in WIDTH bits.
  assign succ_s          = binary_q + WIDTH'(1);
  assign prev_all_ones_s = &binary_q;

  // Next-state / next-output computation for the tracking FSM.
  always_comb begin
    state_d    = state_q;
    binary_d   = binary_q;
    valid_d    = 1'b0;
    overflow_d = overflow_q;
`ifdef GRAY_DECODER_SEQ_CHECK_EN
    error_d    = error_q;
`endif
    if (En) begin
      // Decoding continues in every state; only the checking differs.
      binary_d = dec_s;
      valid_d  = 1'b1;
      case (state_q)
        GD_EMPTY: begin
          state_d = GD_TRACK;
        end
        GD_TRACK: begin
`ifdef GRAY_DECODER_SEQ_CHECK_EN
          if (dec_s == binary_q) begin
            state_d = GD_TRACK;
          end else if (dec_s == succ_s) begin
            if (prev_all_ones_s) begin
              overflow_d = 1'b1;
            end else begin
              overflow_d = overflow_q;
            end
          end else begin
            error_d = 1'b1;
            state_d = GD_FAULT;
          end
`else
          // Every sample is legal; only a wrap from all-ones to zero is noted.
          if (prev_all_ones_s && (dec_s == succ_s)) begin
            overflow_d = 1'b1;
          end else begin
            overflow_d = overflow_q;
          end
`endif
        end
`ifdef GRAY_DECODER_SEQ_CHECK_EN
        GD_FAULT: begin
          // Terminal until Reset; flags frozen.
          state_d = GD_FAULT;
        end
`endif
        default: begin
          state_d = GD_EMPTY;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= GD_EMPTY;
      binary_q   <= {WIDTH{1'b0}};
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
`ifdef GRAY_DECODER_SEQ_CHECK_EN
      error_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      binary_q   <= binary_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
`ifdef GRAY_DECODER_SEQ_CHECK_EN
      error_q    <= error_d;
`endif
    end
  end

  assign Binary   = binary_q;
  assign Valid    = valid_q;
  assign Overflow = overflow_q;
`ifdef GRAY_DECODER_SEQ_CHECK_EN
  assign Error    = error_q;
`else
  assign Error    = 1'b0;
`endif

endmodule

// File: tb/tb_gray_decoder.sv
// tb_gray_decoder
// Directed-vector bench for gray_decoder (WIDTH = 3) with a behavioural
// reference model and per-cycle output comparison.
module tb_gray_decoder;

  localparam int W = 3;
  localparam int N = 8;

`ifdef GRAY_DECODER_SEQ_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic         Clk;
  logic         Reset;
  logic         En;
  logic [W-1:0] GrayIn;
  logic [W-1:0] Binary;
  logic         Valid;
  logic         Overflow;
  logic         Error;

  int n_checks;
  int n_fail;
  bit checking;

  gray_decoder #(.WIDTH(W)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .En       (En),
    .GrayIn   (GrayIn),
    .Binary   (Binary),
    .Valid    (Valid),
    .Overflow (Overflow),
    .Error    (Error)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: decode by searching the count whose Gray code matches.
  function automatic int gray_value(input logic [W-1:0] g);
    for (int n = 0; n < N; n++) begin
      if (((n ^ (n >> 1)) & (N - 1)) == int'(g)) return n;
    end
    return -1;
  endfunction

  int m_bin;
  bit m_valid, m_ovf, m_err, m_have_ref, m_faulted;

  initial begin
    m_bin = 0; m_valid = 0; m_ovf = 0; m_err = 0; m_have_ref = 0; m_faulted = 0;
  end

  always @(posedge Clk) begin
    int d;
    if (Reset) begin
      m_bin = 0; m_valid = 0; m_ovf = 0; m_err = 0; m_have_ref = 0; m_faulted = 0;
    end else if (En) begin
      d = gray_value(GrayIn);
      m_valid = 1;
      if (m_have_ref && !m_faulted) begin
        if (d == m_bin) begin
          // hold
        end else if (d == (m_bin + 1) % N) begin
          if (m_bin == N - 1) m_ovf = 1;
        end else if (CHECK_EN) begin
          m_err = 1;
          m_faulted = 1;
        end
      end
      m_bin = d;
      m_have_ref = 1;
    end else begin
      m_valid = 0;
    end
  end

  // Every cycle after the first reset, all outputs must match the model.
  always @(negedge Clk) begin
    if (checking) begin
      check("cyc_binary", 16'(Binary), 16'(m_bin));
      check("cyc_valid", 16'(Valid), 16'(m_valid));
      check("cyc_overflow", 16'(Overflow), 16'(m_ovf));
      check("cyc_error", 16'(Error), 16'(m_err));
    end
  end

  // Apply inputs for one rising edge; returns on the following falling edge.
  task automatic step(input bit rst, input bit en, input logic [W-1:0] g);
    Reset  = rst;
    En     = en;
    GrayIn = g;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  logic [W-1:0] gseq [N];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    checking = 0;
    gseq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    Reset = 1'b1; En = 1'b0; GrayIn = 3'b000;

    // Reset state
    step(1'b1, 1'b0, 3'b000);
    checking = 1;
    step(1'b1, 1'b0, 3'b000);
    check("rst_binary", 16'(Binary), 16'd0);
    check("rst_valid", 16'(Valid), 16'd0);
    check("rst_overflow", 16'(Overflow), 16'd0);
    check("rst_error", 16'(Error), 16'd0);

    // Full count 0..7
    for (int i = 0; i < N; i++) begin
      step(1'b0, 1'b1, gseq[i]);
      check("seq_binary", 16'(Binary), 16'(i));
      check("seq_valid", 16'(Valid), 16'd1);
    end
    check("seq_overflow", 16'(Overflow), 16'd0);
    check("seq_error", 16'(Error), 16'd0);

    // Wrap 7 -> 0 sets Overflow; hold at 0 is legal and Overflow stays set
    step(1'b0, 1'b1, 3'b000);
    check("wrap_binary", 16'(Binary), 16'd0);
    check("wrap_overflow", 16'(Overflow), 16'd1);
    step(1'b0, 1'b1, 3'b000);
    check("hold_overflow", 16'(Overflow), 16'd1);
    check("hold_error", 16'(Error), 16'd0);

    // First sample after reset is arbitrary
    step(1'b1, 1'b0, 3'b000);
    step(1'b0, 1'b1, 3'b110);
    check("first_binary", 16'(Binary), 16'd4);
    check("first_error", 16'(Error), 16'd0);
    step(1'b0, 1'b1, 3'b111);
    check("next_binary", 16'(Binary), 16'd5);
    check("next_error", 16'(Error), 16'd0);

    // Illegal jump 1 -> 3
    step(1'b1, 1'b0, 3'b000);
    step(1'b0, 1'b1, 3'b001);
    step(1'b0, 1'b1, 3'b010);
    check("jump_binary", 16'(Binary), 16'd3);
    check("jump_valid", 16'(Valid), 16'd1);
    check("jump_error", 16'(Error), 16'(CHECK_EN));
    step(1'b0, 1'b1, 3'b000);
    check("jump_no_overflow", 16'(Overflow), 16'd0);
    check("jump_error_sticky", 16'(Error), 16'(CHECK_EN));

    // Reset wins over En on the same edge
    step(1'b1, 1'b1, 3'b011);
    check("rsten_binary", 16'(Binary), 16'd0);
    check("rsten_valid", 16'(Valid), 16'd0);
    check("rsten_error", 16'(Error), 16'd0);
    step(1'b0, 1'b1, 3'b101);
    check("after_rst_binary", 16'(Binary), 16'd6);
    check("after_rst_error", 16'(Error), 16'd0);

    // En toggling with a stable input
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 3'b101);
      check("toggle_off_valid", 16'(Valid), 16'd0);
      check("toggle_off_binary", 16'(Binary), 16'd6);
      step(1'b0, 1'b1, 3'b101);
      check("toggle_on_valid", 16'(Valid), 16'd1);
    end
    // Input changes while En is low must not be seen
    step(1'b0, 1'b0, 3'b111);
    check("idle_binary", 16'(Binary), 16'd6);
    step(1'b0, 1'b1, 3'b100);
    check("step_binary", 16'(Binary), 16'd7);
    check("step_error", 16'(Error), 16'd0);

    step(1'b0, 1'b0, 3'b100);
    checking = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
